// File: rtl/pipe_pkg.sv
// Shared definitions for the hxd32 fetch stage: default constants and the
// instruction/PC packet carried through the skid buffer and IF/ID register.
package pipe_pkg;

  localparam int          INST_W       = 32;
  localparam int          PC_W         = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              valid;
  } fetch_pkt_t;

endpackage

// File: rtl/pipe_ifu_if.sv
// Instruction RAM read port: address/strobe from the fetch unit, data back
// one cycle after an enabled read.
interface pipe_ifu_if #(
  parameter int XLEN = 32
);
  logic            rd_en;
  logic [XLEN-1:0] rd_addr;
  logic [31:0]     rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/pipe_ifu_skid.sv
// One-entry skid register holding an instruction that returned while IF/ID
// was stalled; clear dominates load, load dominates drain.
module pipe_ifu_skid
  import pipe_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic              clear_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [PC_W-1:0]   pc_i,
  output fetch_pkt_t        pkt_o
);

  fetch_pkt_t pkt_q;
  fetch_pkt_t pkt_d;

  always_comb begin
    pkt_d = pkt_q;
    if (clear_i) begin
      pkt_d.valid = 1'b0;
    end else if (load_i) begin
      pkt_d.inst  = inst_i;
      pkt_d.pc    = pc_i;
      pkt_d.valid = 1'b1;
    end else if (drain_i) begin
      pkt_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign pkt_o = pkt_q;

endmodule

// File: rtl/pipe_ifu.sv
// hxd32 instruction fetch stage: fetch PC, IRAM read issue, and the IF/ID
// register, with a skid entry so stalls never lose or repeat a read.
module pipe_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = pipe_pkg::RESET_PC_DEF,
  parameter logic [31:0]     NOP_INST = pipe_pkg::NOP_INST_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   jmp_pc_i,
  pipe_ifu_if.master        iram,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              inst_valid_o
);
  import pipe_pkg::*;

  logic            issue;
  logic [XLEN-1:0] rd_addr;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q;
  logic            req_vld_q;
  fetch_pkt_t      out_q, out_d;
  fetch_pkt_t      skid_pkt;
  logic            skid_load, skid_drain, skid_clear;

  // A flush always issues its target, even while the hazard unit stalls.
  assign issue   = flush_i | ~stall_i;
  assign rd_addr = flush_i ? {jmp_pc_i[XLEN-1:2], 2'b00} : fetch_pc_q;

  assign iram.rd_en   = issue;
  assign iram.rd_addr = rd_addr;

  assign fetch_pc_d = issue ? rd_addr + XLEN'(4) : fetch_pc_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      req_vld_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_vld_q  <= issue;
      if (issue) begin
        req_pc_q <= rd_addr;
      end
    end
  end

  always_comb begin
    out_d      = out_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;
    if (flush_i) begin
      out_d.inst  = NOP_INST;
      out_d.valid = 1'b0;
      skid_clear  = 1'b1;
    end else if (stall_i) begin
      skid_load = req_vld_q;
    end else if (skid_pkt.valid) begin
      out_d      = skid_pkt;
      skid_drain = 1'b1;
    end else begin
      out_d.inst  = req_vld_q ? iram.rd_data : NOP_INST;
      out_d.pc    = req_pc_q;
      out_d.valid = req_vld_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q <= '{inst: NOP_INST, pc: RESET_PC, valid: 1'b0};
    end else begin
      out_q <= out_d;
    end
  end

  pipe_ifu_skid u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .inst_i  (iram.rd_data),
    .pc_i    (req_pc_q),
    .pkt_o   (skid_pkt)
  );

  assign inst_o       = out_q.inst;
  assign pc_o         = out_q.pc;
  assign inst_valid_o = out_q.valid;

  // No read issues while stalled, so a pending read and a held entry never coexist.
  a_req_skid_excl: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                    !(req_vld_q && skid_pkt.valid));

endmodule

// File: tb/tb_pipe_ifu.sv
// Directed bench for pipe_ifu: IRAM model returns word = address; inputs
// change and outputs are sampled on the falling clock edge.
module tb_pipe_ifu;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] jmp_pc_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  pipe_ifu_if #(.XLEN(32)) iram_bus ();

  pipe_ifu #(.XLEN(32)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .jmp_pc_i     (jmp_pc_i),
    .iram         (iram_bus.master),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk_i = ~clk_i;

  initial iram_bus.rd_data = 32'h0;
  always @(posedge clk_i) begin
    if (iram_bus.rd_en) iram_bus.rd_data <= iram_bus.rd_addr;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                         input logic vld);
    check_vec({tag, ".inst"}, inst_o, inst);
    check_vec({tag, ".pc"}, pc_o, pc);
    check_vec({tag, ".valid"}, {31'b0, inst_valid_o}, {31'b0, vld});
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  initial begin
    rst_n_i  = 1'b0;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    jmp_pc_i = 32'h0;
    tick(); tick();
    chk_out("reset", NOP, 32'h0, 1'b0);

    // 1: start-up stream
    rst_n_i = 1'b1;
    #1;
    check_vec("t1.en0", {31'b0, iram_bus.rd_en}, 32'd1);
    check_vec("t1.addr0", iram_bus.rd_addr, 32'h0);
    tick();
    check_vec("t1.addr1", iram_bus.rd_addr, 32'h4);
    chk_out("t1.c1", NOP, 32'h0, 1'b0);
    tick();
    check_vec("t1.addr2", iram_bus.rd_addr, 32'h8);
    chk_out("t1.c2", 32'h0, 32'h0, 1'b1);
    tick();
    chk_out("t1.c3", 32'h4, 32'h4, 1'b1);
    tick();
    chk_out("t1.c4", 32'h8, 32'h8, 1'b1);
    tick();
    chk_out("t1.c5", 32'hC, 32'hC, 1'b1);

    // 2: stall three cycles with 0x10 in flight
    stall_i = 1'b1;
    #1;
    check_vec("t2.en_stall", {31'b0, iram_bus.rd_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec("t2.en_hold", {31'b0, iram_bus.rd_en}, 32'd0);
      chk_out("t2.hold", 32'hC, 32'hC, 1'b1);
    end
    stall_i = 1'b0;
    #1;
    check_vec("t2.addr_rel", iram_bus.rd_addr, 32'h14);
    tick();
    chk_out("t2.skid", 32'h10, 32'h10, 1'b1);
    tick();
    chk_out("t2.next", 32'h14, 32'h14, 1'b1);

    // 3: flush to 0x100
    flush_i  = 1'b1;
    jmp_pc_i = 32'h100;
    #1;
    check_vec("t3.addr", iram_bus.rd_addr, 32'h100);
    tick();
    flush_i = 1'b0;
    chk_out("t3.bubble", NOP, 32'h14, 1'b0);
    tick();
    chk_out("t3.target", 32'h100, 32'h100, 1'b1);

    // 4: fill skid then flush+stall together
    stall_i = 1'b1;
    tick();
    chk_out("t4.held", 32'h100, 32'h100, 1'b1);
    flush_i  = 1'b1;
    jmp_pc_i = 32'h200;
    #1;
    check_vec("t4.addr", iram_bus.rd_addr, 32'h200);
    check_vec("t4.en", {31'b0, iram_bus.rd_en}, 32'd1);
    tick();
    flush_i = 1'b0;
    stall_i = 1'b0;
    chk_out("t4.bubble", NOP, 32'h100, 1'b0);
    tick();
    chk_out("t4.target", 32'h200, 32'h200, 1'b1);
    tick();
    chk_out("t4.after", 32'h204, 32'h204, 1'b1);

    // 5: misaligned target and address wrap
    flush_i  = 1'b1;
    jmp_pc_i = 32'h103;
    #1;
    check_vec("t5.align", iram_bus.rd_addr, 32'h100);
    tick();
    flush_i = 1'b0;
    tick();
    chk_out("t5.aligned", 32'h100, 32'h100, 1'b1);
    flush_i  = 1'b1;
    jmp_pc_i = 32'hFFFF_FFFC;
    #1;
    check_vec("t5.top", iram_bus.rd_addr, 32'hFFFF_FFFC);
    tick();
    flush_i = 1'b0;
    #1;
    check_vec("t5.wrap_addr", iram_bus.rd_addr, 32'h0);
    tick();
    chk_out("t5.top_out", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    tick();
    chk_out("t5.wrap_out", 32'h0, 32'h0, 1'b1);

    // 6: asynchronous reset while HELD
    stall_i = 1'b1;
    tick();
    #3;
    rst_n_i = 1'b0;
    #1;
    chk_out("t6.async", NOP, 32'h0, 1'b0);
    tick();
    rst_n_i = 1'b1;
    stall_i = 1'b0;
    #1;
    check_vec("t6.addr0", iram_bus.rd_addr, 32'h0);
    tick();
    chk_out("t6.c1", NOP, 32'h0, 1'b0);
    tick();
    chk_out("t6.c2", 32'h0, 32'h0, 1'b1);
    tick();
    chk_out("t6.c3", 32'h4, 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
